// File: rtl/host_axi_pkg.sv
// Shared constants and FSM state encodings for the host-memory AXI4 slave.
package host_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_slave_sdp_ram.sv
// Simple-dual-port RAM: byte-enabled write port, 1-cycle registered read port (read-first).
module axi_slave_sdp_ram #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Only the output register is reset; storage survives srst.
  always_ff @(posedge clk) begin
    if (srst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/host_mem_axi_slave.sv
// AXI4 INCR-burst slave backed by on-chip RAM; independent single-outstanding read and write FSMs.
module host_mem_axi_slave
  import host_axi_pkg::*;
#(
  parameter int unsigned                   C_S_AXI_ID_WIDTH   = 4,
  parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_S_AXI_DATA_WIDTH = 512,
  parameter int unsigned                   MEM_DEPTH_LOG2     = 12,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  localparam int unsigned BPB_LOG2 = $clog2(C_S_AXI_DATA_WIDTH/8);

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

  function automatic idx_t word_index(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
    return MEM_DEPTH_LOG2'((addr - BASE_ADDR) >> BPB_LOG2);
  endfunction

  // Write channel
  wr_state_e                    w_state, w_state_n;
  idx_t                         w_idx, w_idx_n;
  logic [7:0]                   w_len, w_len_n, w_cnt, w_cnt_n;
  logic [C_S_AXI_ID_WIDTH-1:0]  bid_q, bid_n;
  logic [1:0]                   bresp_q, bresp_n;
  logic                         awready_q, wready_q, bvalid_q;
  logic                         w_fire;

  always_comb begin
    w_state_n = w_state;
    w_idx_n   = w_idx;
    w_len_n   = w_len;
    w_cnt_n   = w_cnt;
    bid_n     = bid_q;
    bresp_n   = bresp_q;
    w_fire    = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          bid_n     = s_axi_awid;
          w_idx_n   = word_index(s_axi_awaddr);
          w_len_n   = s_axi_awlen;
          w_cnt_n   = '0;
          w_state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          w_fire  = 1'b1;
          w_idx_n = w_idx + 1'b1;
          w_cnt_n = w_cnt + 1'b1;
          // Burst ends on whichever of len or wlast comes first; disagreement is an error.
          if ((w_cnt == w_len) || s_axi_wlast) begin
            bresp_n   = ((w_cnt == w_len) != s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
            w_state_n = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi_bready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      w_state   <= W_IDLE;
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state   <= w_state_n;
      w_idx     <= w_idx_n;
      w_len     <= w_len_n;
      w_cnt     <= w_cnt_n;
      bid_q     <= bid_n;
      bresp_q   <= bresp_n;
      awready_q <= (w_state_n == W_IDLE);
      wready_q  <= (w_state_n == W_DATA);
      bvalid_q  <= (w_state_n == W_RESP);
    end
  end

  // Read channel
  rd_state_e                    r_state, r_state_n;
  idx_t                         r_idx, r_idx_n;
  logic [7:0]                   r_len, r_len_n, r_cnt, r_cnt_n;
  logic [C_S_AXI_ID_WIDTH-1:0]  rid_q, rid_n;
  logic                         rlast_q, rlast_n;
  logic                         arready_q, rvalid_q;
  logic                         r_issue;

  always_comb begin
    r_state_n = r_state;
    r_idx_n   = r_idx;
    r_len_n   = r_len;
    r_cnt_n   = r_cnt;
    rid_n     = rid_q;
    rlast_n   = rlast_q;
    r_issue   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          rid_n     = s_axi_arid;
          r_idx_n   = word_index(s_axi_araddr);
          r_len_n   = s_axi_arlen;
          r_cnt_n   = '0;
          r_state_n = R_FETCH;
        end
      end
      R_FETCH: begin
        r_issue   = 1'b1;
        rlast_n   = (r_cnt == r_len);
        r_state_n = R_DATA;
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          rlast_n = 1'b0;
          if (rlast_q) begin
            r_state_n = R_IDLE;
          end else begin
            r_idx_n   = r_idx + 1'b1;
            r_cnt_n   = r_cnt + 1'b1;
            r_state_n = R_FETCH;
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state   <= R_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      rid_q     <= '0;
      rlast_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state   <= r_state_n;
      r_idx     <= r_idx_n;
      r_len     <= r_len_n;
      r_cnt     <= r_cnt_n;
      rid_q     <= rid_n;
      rlast_q   <= rlast_n;
      arready_q <= (r_state_n == R_IDLE);
      rvalid_q  <= (r_state_n == R_DATA);
    end
  end

  axi_slave_sdp_ram #(
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .srst  (srst),
    .we    (w_fire & ~srst),
    .waddr (w_idx),
    .wdata (s_axi_wdata),
    .wbe   (s_axi_wstrb),
    .re    (r_issue & ~srst),
    .raddr (r_idx),
    .rdata (s_axi_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_host_mem_axi_slave.sv
// Directed testbench for host_mem_axi_slave with a 16-word RAM at a non-zero base address.
module tb_host_mem_axi_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned TMO  = 50;

  logic         clk = 1'b0;
  logic         srst;
  logic [3:0]   s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [31:0]  s_axi_awaddr, s_axi_araddr;
  logic [7:0]   s_axi_awlen, s_axi_arlen;
  logic         s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [511:0] s_axi_wdata, s_axi_rdata;
  logic [63:0]  s_axi_wstrb;
  logic [1:0]   s_axi_bresp, s_axi_rresp;
  logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic         s_axi_rlast, s_axi_rvalid, s_axi_rready;

  int checks   = 0;
  int failures = 0;

  logic [511:0] rd_data [16];
  logic         rd_last [16];
  logic [3:0]   rd_id;
  logic [1:0]   rd_resp;
  logic [1:0]   wresp;
  logic [3:0]   wbid;
  int unsigned  bwait, rlat;
  logic [511:0] exp_v;

  host_mem_axi_slave #(
    .C_S_AXI_ID_WIDTH   (4),
    .C_S_AXI_ADDR_WIDTH (32),
    .C_S_AXI_DATA_WIDTH (512),
    .MEM_DEPTH_LOG2     (4),
    .BASE_ADDR          (BASE)
  ) dut (
    .clk(clk), .srst(srst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] waddr_of(input int unsigned w);
    return BASE + w * 64;
  endfunction

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                           input int unsigned nbeats, input int unsigned last_at,
                           input logic [511:0] d0, input logic [63:0] strb, input int unsigned hold,
                           output logic [1:0] resp, output logic [3:0] bid, output int unsigned bw);
    int unsigned t;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < TMO) begin @(negedge clk); t++; end
    chk("aw_ready", s_axi_awready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    chk("aw_to_wready_lat", s_axi_wready, 1);
    for (int unsigned k = 0; k < nbeats; k++) begin
      s_axi_wdata = d0 + k; s_axi_wstrb = strb; s_axi_wlast = (k == last_at); s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < TMO) begin @(negedge clk); t++; end
      chk("w_ready", s_axi_wready, 1);
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    bw = 0;
    while (!s_axi_bvalid && bw < TMO) begin @(negedge clk); bw++; end
    chk("b_valid", s_axi_bvalid, 1);
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("b_valid_hold", s_axi_bvalid, 1);
    end
    resp = s_axi_bresp; bid = s_axi_bid;
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk("b_valid_drop", s_axi_bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          output int unsigned lat);
    int unsigned t;
    lat = 0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < TMO) begin @(negedge clk); t++; end
    chk("ar_ready", s_axi_arready, 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    for (int unsigned k = 0; k <= 32'(len); k++) begin
      t = 0;
      while (!s_axi_rvalid && t < TMO) begin @(negedge clk); t++; end
      chk("r_valid", s_axi_rvalid, 1);
      if (k == 0) lat = t;
      rd_data[k] = s_axi_rdata; rd_last[k] = s_axi_rlast; rd_id = s_axi_rid; rd_resp = s_axi_rresp;
      @(negedge clk);
    end
    s_axi_rready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;

    // Reset state and ready timing
    repeat (3) @(negedge clk);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    srst = 1'b0;
    chk("rel_awready_pre", s_axi_awready, 0);
    @(negedge clk);
    chk("rel_awready", s_axi_awready, 1);
    chk("rel_arready", s_axi_arready, 1);
    chk("rel_wready", s_axi_wready, 0);

    // 4-beat burst to BASE+0x40 (words 1..4)
    axi_write(waddr_of(1), 8'd3, 4'h3, 4, 3, 512'd0, '1, 0, wresp, wbid, bwait);
    chk("w1_bresp", wresp, 2'b00);
    chk("w1_bid", wbid, 4'h3);
    axi_read(waddr_of(1), 8'd3, 4'h5, rlat);
    chk("r1_latency", rlat, 1);
    chk("r1_rid", rd_id, 4'h5);
    chk("r1_rresp", rd_resp, 2'b00);
    for (int unsigned k = 0; k < 4; k++) begin
      chk($sformatf("r1_data%0d", k), rd_data[k], k);
      chk($sformatf("r1_last%0d", k), rd_last[k], k == 3);
    end

    // Partial strobe on word 5; read with unaligned low address bits
    axi_write(waddr_of(5), 8'd0, 4'h1, 1, 0, '1, '1, 0, wresp, wbid, bwait);
    axi_write(waddr_of(5), 8'd0, 4'h1, 1, 0, '0, 64'h1, 0, wresp, wbid, bwait);
    axi_read(waddr_of(5) + 32'h7, 8'd0, 4'h2, rlat);
    exp_v = '1; exp_v[7:0] = 8'h00;
    chk("strb_data", rd_data[0], exp_v);
    chk("strb_last", rd_last[0], 1);

    // Length mismatch: early wlast, then missing wlast
    axi_write(waddr_of(12), 8'd3, 4'h7, 2, 1, 512'd90, '1, 0, wresp, wbid, bwait);
    chk("early_wlast_bresp", wresp, 2'b10);
    chk("early_wlast_bwait", bwait, 0);
    axi_write(waddr_of(12), 8'd1, 4'h8, 2, 99, 512'd90, '1, 0, wresp, wbid, bwait);
    chk("no_wlast_bresp", wresp, 2'b10);
    chk("no_wlast_bid", wbid, 4'h8);

    // Read backpressure: words 2..3 hold 1 and 2
    chk("bp_arready", s_axi_arready, 1);
    s_axi_arid = 4'h6; s_axi_araddr = waddr_of(2); s_axi_arlen = 8'd1; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    chk("bp_rvalid_early", s_axi_rvalid, 0);
    @(negedge clk);
    for (int unsigned i = 0; i < 5; i++) begin
      chk("bp_hold_rvalid", s_axi_rvalid, 1);
      chk("bp_hold_rdata", s_axi_rdata, 512'd1);
      chk("bp_hold_rlast", s_axi_rlast, 0);
      @(negedge clk);
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk("bp_fetch_gap", s_axi_rvalid, 0);
    @(negedge clk);
    chk("bp_beat1_rvalid", s_axi_rvalid, 1);
    chk("bp_beat1_rdata", s_axi_rdata, 512'd2);
    chk("bp_beat1_rlast", s_axi_rlast, 1);
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk("bp_done_rvalid", s_axi_rvalid, 0);
    chk("bp_done_arready", s_axi_arready, 1);

    // B backpressure
    axi_write(waddr_of(6), 8'd0, 4'h9, 1, 0, 512'd66, '1, 5, wresp, wbid, bwait);
    chk("bhold_bresp", wresp, 2'b00);
    chk("bhold_bid", wbid, 4'h9);

    // Wrap at RAM depth: words 15 then 0
    axi_write(waddr_of(15), 8'd1, 4'h2, 2, 1, 512'h55, '1, 0, wresp, wbid, bwait);
    chk("wrap_bresp", wresp, 2'b00);
    axi_read(waddr_of(15), 8'd1, 4'h4, rlat);
    chk("wrap_beat0", rd_data[0], 512'h55);
    chk("wrap_beat1", rd_data[1], 512'h56);
    chk("wrap_last1", rd_last[1], 1);

    // Same-cycle read/write collision on word 7 returns old data
    axi_write(waddr_of(7), 8'd0, 4'h1, 1, 0, 512'h70, '1, 0, wresp, wbid, bwait);
    chk("cc_awready", s_axi_awready, 1);
    chk("cc_arready", s_axi_arready, 1);
    s_axi_awid = 4'h1; s_axi_awaddr = waddr_of(7); s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
    s_axi_arid = 4'h2; s_axi_araddr = waddr_of(7); s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    s_axi_wdata = 512'h77; s_axi_wstrb = '1; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    chk("cc_wready", s_axi_wready, 1);
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("cc_rvalid", s_axi_rvalid, 1);
    chk("cc_rdata_old", s_axi_rdata, 512'h70);
    chk("cc_bvalid", s_axi_bvalid, 1);
    chk("cc_bresp", s_axi_bresp, 2'b00);
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    axi_read(waddr_of(7), 8'd0, 4'h3, rlat);
    chk("cc_rdata_new", rd_data[0], 512'h77);

    // Reset in the middle of a 4-beat write to words 8..11
    axi_write(waddr_of(8), 8'd3, 4'h1, 4, 3, 512'd100, '1, 0, wresp, wbid, bwait);
    chk("mid_aw_ready", s_axi_awready, 1);
    s_axi_awid = 4'hA; s_axi_awaddr = waddr_of(8); s_axi_awlen = 8'd3; s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wdata = 512'd200; s_axi_wstrb = '1; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_wdata = 512'd201;
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    chk("mid_pre_bid", s_axi_bid, 4'hA);
    srst = 1'b1;
    @(negedge clk);
    chk("mid_awready", s_axi_awready, 0);
    chk("mid_wready", s_axi_wready, 0);
    chk("mid_bvalid", s_axi_bvalid, 0);
    chk("mid_bresp", s_axi_bresp, 0);
    chk("mid_bid", s_axi_bid, 0);
    chk("mid_arready", s_axi_arready, 0);
    chk("mid_rvalid", s_axi_rvalid, 0);
    chk("mid_rlast", s_axi_rlast, 0);
    chk("mid_rid", s_axi_rid, 0);
    chk("mid_rdata", s_axi_rdata, 0);
    srst = 1'b0;
    @(negedge clk);
    chk("mid_rel_awready", s_axi_awready, 1);
    axi_read(waddr_of(8), 8'd3, 4'hB, rlat);
    chk("mid_word8", rd_data[0], 512'd200);
    chk("mid_word9", rd_data[1], 512'd201);
    chk("mid_word10", rd_data[2], 512'd102);
    chk("mid_word11", rd_data[3], 512'd103);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/host_mem_axi_slave.md
Name: host_mem_axi_slave

Overview:
AXI4 memory-mapped slave (responder) backed by on-chip simple-dual-port RAM. It is the counterpart of the host DMA master: it answers that master's read bursts (image/weight fetch) and absorbs its write bursts (result write-back). Used as the host-memory model in simulation and as a scratch buffer on-chip. Only INCR bursts with full-width beats are supported; cache/prot/lock/qos/user/size/burst signals are not ports.

Parameters:
C_S_AXI_ID_WIDTH, 4, AXI ID width
C_S_AXI_ADDR_WIDTH, 32, byte address width
C_S_AXI_DATA_WIDTH, 512, data width; bytes per beat BPB = DATA_WIDTH/8
MEM_DEPTH_LOG2, 12, log2 of RAM depth in beats
BASE_ADDR, 0, byte address mapped to RAM word 0

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
s_axi_awid  in  ID  write burst ID
s_axi_awaddr  in  ADDR  write start byte address
s_axi_awlen  in  8  beats-1
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  DATA  write data
s_axi_wstrb  in  DATA/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bid  out  ID  response ID (= latched awid)
s_axi_bresp  out  2  OKAY 2'b00 / SLVERR 2'b10
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_arid  in  ID  read burst ID
s_axi_araddr  in  ADDR  read start byte address
s_axi_arlen  in  8  beats-1
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rid  out  ID  read ID (= latched arid)
s_axi_rdata  out  DATA  read data
s_axi_rresp  out  2  always OKAY
s_axi_rlast  out  1  last read beat
s_axi_rvalid / s_axi_rready  out / in  1  R handshake

Behaviour:
- All outputs are registered. Reset values: every ready, valid, rlast, resp, id and rdata is 0. Ready signals rise the cycle after srst deasserts.
- Word index = ((addr - BASE_ADDR) >> log2(BPB)) mod 2^MEM_DEPTH_LOG2. Low address bits are ignored. Increment is +1 per beat and wraps at the RAM depth; a wrapped access still returns OKAY.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, word index and len; clear beat count; go to W_DATA with awready=0.
  - W_DATA: wready=1. Each W handshake writes RAM in the same cycle with wstrb byte enables, then index+1 and count+1.
  - Exit from W_DATA happens on the beat where count==len or wlast=1. If (count==len) != wlast, bresp=SLVERR; otherwise OKAY. Go to W_RESP.
  - W_RESP: bvalid=1 until bready, then back to W_IDLE. AW→first wready latency is 1 cycle. W throughput is 1 beat/cycle.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch id, index and len; go to R_FETCH.
  - R_FETCH: issue RAM read; go to R_DATA.
  - R_DATA: rvalid=1, rdata is registered RAM output, rlast=(count==len). rdata/rlast stay stable until rready.
  - On the R handshake: if last, go to R_IDLE; otherwise index+1, count+1, go to R_FETCH.
  - Latency AR→first rvalid is 2 cycles. Throughput is 1 beat per 2 cycles.
- Read and write channels are fully independent and may be active in the same cycle. A same-address same-cycle collision is read-first: the read returns the old data.
- Only one outstanding burst per direction. A new AW/AR is not accepted until the previous B/R completes.
- srst mid-burst: both FSMs return to IDLE and outputs go to reset values. RAM contents are retained, including partial bursts already written.

Decomposition:
- host_axi_pkg: RESP_OKAY / RESP_SLVERR constants, write-FSM and read-FSM state encodings.
- Sub-module axi_slave_sdp_ram:
  - one write port with byte enables; one read port;
  - 1-cycle registered read, read-first;
  - parameters DATA_WIDTH and DEPTH_LOG2;
  - no reset on its storage.

Test Plan:
- Write awaddr=BASE+0x40, awlen=3, 4 beats with wstrb all-ones, data k → bvalid with bresp=00, bid=awid; reading awaddr=BASE+0x40, arlen=3 returns data 0..3 with rlast only on beat 3.
- Partial strobe: write word 5 all-ones, then write word 5 with wstrb=0x1 and data 0 → reading word 5 gives byte 0 = 0x00 and all other bytes 0xFF.
- Burst length mismatch:
  - awlen=3 with wlast on beat 1 → bresp=10 after 2 beats;
  - awlen=1 with wlast low on beat 1 → bresp=10.
- Backpressure: hold rready=0 for 5 cycles during beat 0 of an arlen=1 read → rdata/rlast/rvalid stay stable; the burst completes normally after release. The same check applies to bready=0 holding bvalid.
- Wrap: MEM_DEPTH_LOG2=4; write word 15, arlen=1 → beat 1 reads word 0. Concurrent AR and AW to the same word in the same cycle → the read returns the pre-write value.
- Reset mid-burst: assert srst after beat 1 of a 4-beat write → all outputs 0 next cycle and awready=1 one cycle after release; words 0-1 hold new data, words 2-3 are unchanged.
